// File: rtl/jtgng_ps2_key_tx.sv
// Purpose: receive raw PS/2 keyboard frames, decode E0/F0/E1 prefixes, emit 11-bit ps2_key events.
// Latency: stop-bit fall -> rx_valid +1 cycle -> key_stb/ps2_key +2 cycles (plus 2 sync + FILTER cycles).
// Backpressure: none; the PS/2 device sets the pace and every output is a single-cycle pulse or held level.
module jtgng_ps2_key_tx #(
    parameter int FILTER  = 4,
    parameter int TIMEOUT = 96000,
    parameter int TW      = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        key_stb,
    output logic [7:0]  rx_byte,
    output logic        rx_valid,
    output logic        frame_err
);
    localparam int FW = $clog2(FILTER + 1);

    typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;

    // input conditioning: {clk, data} pairs
    logic [1:0]    sync1_q, sync1_d, sync2_q, sync2_d;
    logic          clk_f_q, clk_f_d, dat_f_q, dat_f_d, clk_prev_q, clk_prev_d;
    logic [FW-1:0] clk_cnt_q, clk_cnt_d, dat_cnt_q, dat_cnt_d;
    logic          fall;

    // frame receiver
    state_t        state_q, state_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          rx_valid_q, rx_valid_d, frame_err_q, frame_err_d;

    // scan-code decoder
    logic          ext_q, ext_d, rel_q, rel_d;
    logic [2:0]    skip_q, skip_d;
    logic [10:0]   ps2_key_q, ps2_key_d;
    logic          key_stb_q, key_stb_d;

    // two-flop synchroniser, then accept a new level only after FILTER consecutive differing samples
    always_comb begin
        sync1_d    = {ps2_clk, ps2_data};
        sync2_d    = sync1_q;
        clk_f_d    = clk_f_q;
        dat_f_d    = dat_f_q;
        clk_cnt_d  = '0;
        dat_cnt_d  = '0;
        clk_prev_d = clk_f_q;
        if (sync2_q[1] != clk_f_q) begin
            if (clk_cnt_q == FW'(FILTER - 1)) clk_f_d = sync2_q[1];
            else                              clk_cnt_d = clk_cnt_q + 1'b1;
        end
        if (sync2_q[0] != dat_f_q) begin
            if (dat_cnt_q == FW'(FILTER - 1)) dat_f_d = sync2_q[0];
            else                              dat_cnt_d = dat_cnt_q + 1'b1;
        end
    end

    assign fall = clk_prev_q & ~clk_f_q;

    // frame FSM: advances on filtered clock falls, abandons partial frames after TIMEOUT idle cycles
    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        par_d       = par_q;
        tmo_d       = tmo_q;
        rx_byte_d   = rx_byte_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        if (fall) begin
            tmo_d = '0;
            case (state_q)
                IDLE: begin
                    if (!dat_f_q) begin
                        state_d   = DATA;
                        bit_idx_d = 3'd0;
                    end
                end
                DATA: begin
                    shift_d   = {dat_f_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = PAR;
                end
                PAR: begin
                    par_d   = dat_f_q;
                    state_d = STOP;
                end
                default: begin
                    // odd parity: data bits plus parity bit must XOR to 1
                    if (dat_f_q && (^{shift_q, par_q})) begin
                        rx_byte_d  = shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            endcase
        end else if (state_q == IDLE) begin
            tmo_d = '0;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
            tmo_d       = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    // decoder: prefixes set flags, E1 swallows the rest of the Pause sequence, other codes emit an event
    always_comb begin
        ext_d     = ext_q;
        rel_d     = rel_q;
        skip_d    = skip_q;
        ps2_key_d = ps2_key_q;
        key_stb_d = 1'b0;
        if (frame_err_q) begin
            ext_d  = 1'b0;
            rel_d  = 1'b0;
            skip_d = 3'd0;
        end else if (rx_valid_q) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
            end else begin
                case (rx_byte_q)
                    8'hE1: skip_d = 3'd7;
                    8'hE0: ext_d  = 1'b1;
                    8'hF0: rel_d  = 1'b1;
                    8'hFA, 8'hAA, 8'hEE, 8'hFE: ;
                    default: begin
                        ps2_key_d = {~ps2_key_q[10], ~rel_q, ext_q, rx_byte_q};
                        key_stb_d = 1'b1;
                        ext_d     = 1'b0;
                        rel_d     = 1'b0;
                    end
                endcase
            end
        end
    end

    // state registers; idle lines read as 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 2'b11;
            sync2_q     <= 2'b11;
            clk_f_q     <= 1'b1;
            dat_f_q     <= 1'b1;
            clk_prev_q  <= 1'b1;
            clk_cnt_q   <= '0;
            dat_cnt_q   <= '0;
            state_q     <= IDLE;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'd0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            rx_byte_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            ext_q       <= 1'b0;
            rel_q       <= 1'b0;
            skip_q      <= 3'd0;
            ps2_key_q   <= 11'd0;
            key_stb_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            clk_f_q     <= clk_f_d;
            dat_f_q     <= dat_f_d;
            clk_prev_q  <= clk_prev_d;
            clk_cnt_q   <= clk_cnt_d;
            dat_cnt_q   <= dat_cnt_d;
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            ext_q       <= ext_d;
            rel_q       <= rel_d;
            skip_q      <= skip_d;
            ps2_key_q   <= ps2_key_d;
            key_stb_q   <= key_stb_d;
        end
    end

    assign ps2_key   = ps2_key_q;
    assign key_stb   = key_stb_q;
    assign rx_byte   = rx_byte_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_jtgng_ps2_key_tx.sv
// Purpose: exercise the PS/2 receiver/decoder with fixed vectors, corner sequences and random frames.
// Latency: checks land a fixed settle time after each frame's final clock rise.
// Backpressure: none; the bench plays the keyboard and drives the lines at its own pace.
module tb_jtgng_ps2_key_tx;
    localparam int TMO = 400;
    localparam int H   = 10;    // half bit period in clk cycles

    logic        clk = 1'b0;
    logic        rst;
    logic        ps2_clk, ps2_data;
    logic [10:0] ps2_key;
    logic        key_stb, rx_valid, frame_err;
    logic [7:0]  rx_byte;

    int checks = 0;
    int errors = 0;
    int n_rxv = 0, n_ferr = 0, n_stb = 0, n_both = 0;

    jtgng_ps2_key_tx #(.FILTER(4), .TIMEOUT(TMO), .TW(17)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .ps2_key(ps2_key), .key_stb(key_stb), .rx_byte(rx_byte),
        .rx_valid(rx_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // pulse counters sampled on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid)              n_rxv++;
            if (frame_err)             n_ferr++;
            if (key_stb)               n_stb++;
            if (rx_valid && frame_err) n_both++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    // one bit: data set while clock high, optional 2-cycle clock glitch, then a real low phase
    task automatic ps2_bit(input logic v, input bit glitch);
        ps2_data = v;
        if (glitch) begin
            wait_cyc(3); ps2_clk = 1'b0; wait_cyc(2); ps2_clk = 1'b1; wait_cyc(H - 5);
        end else begin
            wait_cyc(H);
        end
        ps2_clk = 1'b0;
        wait_cyc(H);
        ps2_clk = 1'b1;
    endtask

    // bad: 0 clean, 1 parity inverted, 2 stop bit low
    task automatic send_frame(input logic [7:0] b, input logic [1:0] bad, input int nbits, input bit glitch);
        logic [10:0] bits;
        bits = {~(bad == 2'd2), (~^b) ^ (bad == 2'd1), b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(bits[i], glitch);
        ps2_data = 1'b1;
        wait_cyc(H + 20);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] b, input logic [1:0] bad, input bit glitch,
                             input int e_rxv, input int e_err, input int e_stb, input logic [10:0] e_key);
        int r0, f0, s0;
        r0 = n_rxv; f0 = n_ferr; s0 = n_stb;
        send_frame(b, bad, 11, glitch);
        @(negedge clk);
        chk({tag, " rx_valid"}, n_rxv - r0, e_rxv);
        chk({tag, " frame_err"}, n_ferr - f0, e_err);
        chk({tag, " key_stb"}, n_stb - s0, e_stb);
        chk({tag, " ps2_key"}, int'(ps2_key), int'(e_key));
        if (e_rxv != 0) chk({tag, " rx_byte"}, int'(rx_byte), int'(b));
    endtask

    typedef struct {
        logic [7:0]  b;
        logic [1:0]  bad;
        int          rxv;
        int          err;
        int          stb;
        logic [10:0] key;
    } vec_t;

    vec_t tbl[25];

    // reference model state for the random phase
    bit          m_tog, m_ext, m_rel;
    int          m_skip;
    logic [10:0] m_key;

    initial begin
        int f0, r0, s0;
        logic [7:0]  rb;
        logic [1:0]  rbad;
        int          e_stb;

        tbl[0]  = '{8'h1C, 2'd0, 1, 0, 1, 11'h61C};
        tbl[1]  = '{8'hF0, 2'd0, 1, 0, 0, 11'h61C};
        tbl[2]  = '{8'h1C, 2'd0, 1, 0, 1, 11'h01C};
        tbl[3]  = '{8'hE0, 2'd0, 1, 0, 0, 11'h01C};
        tbl[4]  = '{8'h75, 2'd0, 1, 0, 1, 11'h775};
        tbl[5]  = '{8'hE0, 2'd0, 1, 0, 0, 11'h775};
        tbl[6]  = '{8'hF0, 2'd0, 1, 0, 0, 11'h775};
        tbl[7]  = '{8'h75, 2'd0, 1, 0, 1, 11'h175};
        tbl[8]  = '{8'h29, 2'd1, 0, 1, 0, 11'h175};
        tbl[9]  = '{8'h29, 2'd0, 1, 0, 1, 11'h629};
        tbl[10] = '{8'hAA, 2'd0, 1, 0, 0, 11'h629};
        tbl[11] = '{8'hE1, 2'd0, 1, 0, 0, 11'h629};
        tbl[12] = '{8'h14, 2'd0, 1, 0, 0, 11'h629};
        tbl[13] = '{8'h77, 2'd0, 1, 0, 0, 11'h629};
        tbl[14] = '{8'hE1, 2'd0, 1, 0, 0, 11'h629};
        tbl[15] = '{8'hF0, 2'd0, 1, 0, 0, 11'h629};
        tbl[16] = '{8'h14, 2'd0, 1, 0, 0, 11'h629};
        tbl[17] = '{8'hF0, 2'd0, 1, 0, 0, 11'h629};
        tbl[18] = '{8'h77, 2'd0, 1, 0, 0, 11'h629};
        tbl[19] = '{8'hF0, 2'd0, 1, 0, 0, 11'h629};
        tbl[20] = '{8'hFA, 2'd0, 1, 0, 0, 11'h629};
        tbl[21] = '{8'h1C, 2'd0, 1, 0, 1, 11'h01C};
        tbl[22] = '{8'hE0, 2'd0, 1, 0, 0, 11'h01C};
        tbl[23] = '{8'h33, 2'd2, 0, 1, 0, 11'h01C};
        tbl[24] = '{8'h33, 2'd0, 1, 0, 1, 11'h633};

        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
        wait_cyc(5);
        @(negedge clk);
        chk("reset ps2_key", int'(ps2_key), 0);
        chk("reset key_stb", int'(key_stb), 0);
        chk("reset rx_byte", int'(rx_byte), 0);
        chk("reset rx_valid", int'(rx_valid), 0);
        chk("reset frame_err", int'(frame_err), 0);
        rst = 1'b0;
        wait_cyc(10);

        for (int i = 0; i < 25; i++)
            run_frame($sformatf("vec%0d", i), tbl[i].b, tbl[i].bad, 1'b0,
                      tbl[i].rxv, tbl[i].err, tbl[i].stb, tbl[i].key);

        // clock glitches on every bit must not add bits
        run_frame("glitch", 8'h16, 2'd0, 1'b1, 1, 0, 1, 11'h216);

        // partial frame abandoned by timeout
        f0 = n_ferr; r0 = n_rxv;
        send_frame(8'h05, 2'd0, 5, 1'b0);
        wait_cyc(TMO - 70);
        @(negedge clk);
        chk("timeout early", n_ferr - f0, 0);
        wait_cyc(50);
        @(negedge clk);
        chk("timeout err", n_ferr - f0, 1);
        chk("timeout rxv", n_rxv - r0, 0);
        run_frame("after timeout", 8'h05, 2'd0, 1'b0, 1, 0, 1, 11'h605);

        // reset mid-frame
        send_frame(8'h3C, 2'd0, 4, 1'b0);
        ps2_clk = 1'b0;
        wait_cyc(3);
        rst = 1'b1;
        wait_cyc(3);
        @(negedge clk);
        chk("midrst ps2_key", int'(ps2_key), 0);
        chk("midrst rx_byte", int'(rx_byte), 0);
        chk("midrst stb/vld/err", int'({key_stb, rx_valid, frame_err}), 0);
        ps2_clk = 1'b1; ps2_data = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(10);
        run_frame("after rst", 8'h1C, 2'd0, 1'b0, 1, 0, 1, 11'h61C);

        // random frames against the rule-level model, from a fresh reset
        rst = 1'b1; wait_cyc(3); rst = 1'b0; wait_cyc(10);
        m_tog = 0; m_ext = 0; m_rel = 0; m_skip = 0; m_key = 11'd0;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0: rb = 8'hE0;
                1: rb = 8'hF0;
                2: rb = 8'hE1;
                3: rb = 8'hFA;
                default: rb = 8'($urandom_range(0, 255));
            endcase
            rbad  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
            e_stb = 0;
            if (rbad != 2'd0) begin
                m_ext = 0; m_rel = 0; m_skip = 0;
            end else if (m_skip > 0) begin
                m_skip--;
            end else if (rb == 8'hE1) begin
                m_skip = 7;
            end else if (rb == 8'hE0) begin
                m_ext = 1;
            end else if (rb == 8'hF0) begin
                m_rel = 1;
            end else if (!(rb inside {8'hFA, 8'hAA, 8'hEE, 8'hFE})) begin
                m_tog = !m_tog;
                m_key = {m_tog, !m_rel, m_ext, rb};
                e_stb = 1;
                m_ext = 0; m_rel = 0;
            end
            run_frame($sformatf("rnd%0d b=%0h bad=%0d", i, rb, rbad), rb, rbad, 1'b0,
                      (rbad == 2'd0) ? 1 : 0, (rbad != 2'd0) ? 1 : 0, e_stb, m_key);
        end

        chk("rx_valid with frame_err", n_both, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // hard stop so the run always ends
    initial begin
        s0_guard: begin
            #5ms;
            $display("FAIL watchdog: simulation exceeded time budget");
            $fatal(1, "watchdog");
        end
    end

endmodule
